// File: rtl/cr_osf_ob_monitor_pkg.sv
// rtl/cr_osf_ob_monitor_pkg.sv - state enums, event bundle and width helper for the outbound monitor
package cr_osf_ob_monitor_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE,
        CMD_RQE,
        CMD_CQE
    } ob_mon_cmd_st_e;

    typedef enum logic {
        DAT_IDLE,
        DAT_FRAME
    } ob_mon_data_st_e;

    typedef struct packed {
        logic dat_fifo_stall;
        logic pdt_fifo_stall;
        logic ob_stall;
        logic ob_sys_bp;
    } osf_ob_mon_events_t;

    // Width needed to hold a strobe popcount of 0..data_bytes.
    function automatic int beat_amt_width(input int data_bytes);
        return $clog2(data_bytes + 1);
    endfunction

endpackage

// File: rtl/cr_structs.sv
// rtl/cr_structs.sv - shared OSF TLV type codes
package cr_structs;

    localparam logic [7:0] TLV_TYPE_RQE      = 8'h01;
    localparam logic [7:0] TLV_TYPE_CQE      = 8'h02;
    localparam logic [7:0] TLV_TYPE_DATA     = 8'h03;
    localparam logic [7:0] TLV_TYPE_DATA_UNK = 8'h04;

endpackage

// File: rtl/cr_osf_ob_monitor_if.sv
// rtl/cr_osf_ob_monitor_if.sv - observed outbound stream and ingress handshakes
//   ob_tdata/ob_tstrb/ob_tuser : outbound beat, qualified by ob_beat; tuser[0]=SOP, tuser[1]=EOP
//   ob_fifo_empty              : outbound FIFO empty
//   ib_tvalid/ib_tready        : data ingress handshake
//   cg_ib_tvalid/cg_ib_tready  : PDT ingress handshake
//   master drives everything, slave (the monitor) only observes
interface cr_osf_ob_monitor_if #(
    parameter int DATA_BYTES = 8
);
    logic [8*DATA_BYTES-1:0] ob_tdata;
    logic [DATA_BYTES-1:0]   ob_tstrb;
    logic [1:0]              ob_tuser;
    logic                    ob_beat;
    logic                    ob_fifo_empty;
    logic                    ib_tvalid;
    logic                    ib_tready;
    logic                    cg_ib_tvalid;
    logic                    cg_ib_tready;

    modport master (
        output ob_tdata, ob_tstrb, ob_tuser, ob_beat, ob_fifo_empty,
        output ib_tvalid, ib_tready, cg_ib_tvalid, cg_ib_tready
    );

    modport slave (
        input ob_tdata, ob_tstrb, ob_tuser, ob_beat, ob_fifo_empty,
        input ib_tvalid, ib_tready, cg_ib_tvalid, cg_ib_tready
    );
endinterface

// File: rtl/cr_osf_strb_popcnt.sv
// rtl/cr_osf_strb_popcnt.sv - combinational popcount of N byte strobes
//   strb : byte strobes
//   cnt  : number of set strobes
module cr_osf_strb_popcnt #(
    parameter int N = 8,
    parameter int W = $clog2(N + 1)
) (
    input  logic [N-1:0] strb,
    output logic [W-1:0] cnt
);
    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + W'(strb[i]);
        end
    end
endmodule

// File: rtl/cr_osf_ob_monitor.sv
// rtl/cr_osf_ob_monitor.sv - passive OSF outbound stats/protocol monitor
//   clk, rst_n          : core clock, async active-low reset
//   obs                 : observed outbound stream and ingress handshakes (slave modport)
//   ev_*                : per-cycle stall/backpressure events
//   cqe_exit            : pulse after a CQE EOP beat
//   beat_bytes_stb/amt  : payload beat accepted and its byte count
//   frame_cnt_stb       : data TLV header accepted
//   frame_bytes_stb/frame_bytes : data frame closed and its saturated payload byte total
//   proto_err           : SOP/EOP framing violation
//   cmd_active          : between RQE SOP and CQE EOP
//   cmd_latency/_stb    : command duration, only with CR_OSF_OB_MON_LATENCY_EN defined (else tied 0)
// All outputs are registered one cycle after the qualifying input cycle.
module cr_osf_ob_monitor
    import cr_osf_ob_monitor_pkg::*;
    import cr_structs::*;
#(
    parameter int DATA_BYTES = 8,
    parameter int CNT_W      = 32,
    parameter int TYPE_LSB   = 0,
    localparam int AMT_W     = beat_amt_width(DATA_BYTES)
) (
    input  logic             clk,
    input  logic             rst_n,
    cr_osf_ob_monitor_if.slave obs,
    output logic             ev_dat_fifo_stall,
    output logic             ev_pdt_fifo_stall,
    output logic             ev_ob_stall,
    output logic             ev_ob_sys_bp,
    output logic             cqe_exit,
    output logic             beat_bytes_stb,
    output logic [AMT_W-1:0] beat_bytes_amt,
    output logic             frame_cnt_stb,
    output logic             frame_bytes_stb,
    output logic [CNT_W-1:0] frame_bytes,
    output logic             proto_err,
    output logic             cmd_active,
    output logic [CNT_W-1:0] cmd_latency,
    output logic             cmd_latency_stb
);
    logic       sop;
    logic       eop;
    logic [7:0] tlv_type;
    logic       is_rqe;
    logic       is_cqe;
    logic       is_data;
    logic       unused_tdata;

    assign sop      = obs.ob_beat & obs.ob_tuser[0];
    assign eop      = obs.ob_beat & obs.ob_tuser[1];
    assign tlv_type = obs.ob_tdata[TYPE_LSB +: 8];
    assign is_rqe   = sop && (tlv_type == TLV_TYPE_RQE);
    assign is_cqe   = sop && (tlv_type == TLV_TYPE_CQE);
    assign is_data  = sop && ((tlv_type == TLV_TYPE_DATA) || (tlv_type == TLV_TYPE_DATA_UNK));
    assign unused_tdata = ^obs.ob_tdata;

    logic [AMT_W-1:0] amt;

    cr_osf_strb_popcnt #(
        .N (DATA_BYTES),
        .W (AMT_W)
    ) u_popcnt (
        .strb (obs.ob_tstrb),
        .cnt  (amt)
    );

    // Event outputs: free-running, independent of both FSMs.
    osf_ob_mon_events_t ev_d;
    osf_ob_mon_events_t ev_q;

    always_comb begin
        ev_d.dat_fifo_stall = obs.ib_tvalid & ~obs.ib_tready;
        ev_d.pdt_fifo_stall = obs.cg_ib_tvalid & ~obs.cg_ib_tready;
        ev_d.ob_stall       = obs.ob_fifo_empty & cmd_active;
        ev_d.ob_sys_bp      = ~obs.ob_fifo_empty & ~obs.ob_beat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ev_q <= '0;
        else        ev_q <= ev_d;
    end

    assign ev_dat_fifo_stall = ev_q.dat_fifo_stall;
    assign ev_pdt_fifo_stall = ev_q.pdt_fifo_stall;
    assign ev_ob_stall       = ev_q.ob_stall;
    assign ev_ob_sys_bp      = ev_q.ob_sys_bp;

    // Command FSM. orphan_q tracks a multi-beat CQE seen outside a command
    // so its EOP still produces cqe_exit without raising cmd_active.
    ob_mon_cmd_st_e cmd_st;
    ob_mon_cmd_st_e cmd_nxt;
    logic           orphan_q;
    logic           orphan_d;
    logic           cqe_exit_d;

    always_comb begin
        cmd_nxt    = cmd_st;
        orphan_d   = orphan_q;
        cqe_exit_d = 1'b0;
        case (cmd_st)
            CMD_IDLE: begin
                if (sop) orphan_d = 1'b0;
                if (is_rqe) begin
                    cmd_nxt = CMD_RQE;
                end else if (is_cqe) begin
                    if (eop) cqe_exit_d = 1'b1;
                    else     orphan_d   = 1'b1;
                end else if (orphan_q && eop && !sop) begin
                    cqe_exit_d = 1'b1;
                    orphan_d   = 1'b0;
                end
            end
            CMD_RQE: begin
                if (is_cqe) begin
                    if (eop) begin
                        cmd_nxt    = CMD_IDLE;
                        cqe_exit_d = 1'b1;
                    end else begin
                        cmd_nxt = CMD_CQE;
                    end
                end
            end
            CMD_CQE: begin
                if (eop) begin
                    cmd_nxt    = CMD_IDLE;
                    cqe_exit_d = 1'b1;
                end
            end
            default: cmd_nxt = CMD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_st     <= CMD_IDLE;
            orphan_q   <= 1'b0;
            cqe_exit   <= 1'b0;
            cmd_active <= 1'b0;
        end else begin
            cmd_st     <= cmd_nxt;
            orphan_q   <= orphan_d;
            cqe_exit   <= cqe_exit_d;
            cmd_active <= (cmd_nxt != CMD_IDLE);
        end
    end

    // Data FSM and saturating payload accumulator.
    ob_mon_data_st_e  dat_st;
    ob_mon_data_st_e  dat_nxt;
    logic [CNT_W-1:0] acc_q;
    logic [CNT_W-1:0] acc_d;
    logic [CNT_W:0]   sum_wide;
    logic [CNT_W-1:0] acc_sat;
    logic             frame_cnt_d;
    logic             frame_bytes_stb_d;
    logic [CNT_W-1:0] frame_bytes_d;
    logic             beat_stb_d;
    logic [AMT_W-1:0] beat_amt_d;
    logic             proto_err_d;

    assign sum_wide = {1'b0, acc_q} + (CNT_W + 1)'(amt);
    assign acc_sat  = sum_wide[CNT_W] ? {CNT_W{1'b1}} : sum_wide[CNT_W-1:0];

    always_comb begin
        dat_nxt           = dat_st;
        acc_d             = acc_q;
        frame_cnt_d       = 1'b0;
        frame_bytes_stb_d = 1'b0;
        frame_bytes_d     = '0;
        beat_stb_d        = 1'b0;
        beat_amt_d        = '0;
        proto_err_d       = 1'b0;
        if (sop) begin
            // A SOP inside a frame drops that frame, then is treated as if from IDLE.
            if (dat_st == DAT_FRAME) proto_err_d = 1'b1;
            dat_nxt = DAT_IDLE;
            if (is_data) begin
                frame_cnt_d = 1'b1;
                acc_d       = '0;
                if (eop) frame_bytes_stb_d = 1'b1;
                else     dat_nxt           = DAT_FRAME;
            end
        end else if (obs.ob_beat) begin
            if (dat_st == DAT_FRAME) begin
                beat_stb_d = 1'b1;
                beat_amt_d = amt;
                acc_d      = acc_sat;
                if (eop) begin
                    frame_bytes_stb_d = 1'b1;
                    frame_bytes_d     = acc_sat;
                    dat_nxt           = DAT_IDLE;
                end
            end else if (eop) begin
                proto_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_st          <= DAT_IDLE;
            acc_q           <= '0;
            frame_cnt_stb   <= 1'b0;
            frame_bytes_stb <= 1'b0;
            frame_bytes     <= '0;
            beat_bytes_stb  <= 1'b0;
            beat_bytes_amt  <= '0;
            proto_err       <= 1'b0;
        end else begin
            dat_st          <= dat_nxt;
            acc_q           <= acc_d;
            frame_cnt_stb   <= frame_cnt_d;
            frame_bytes_stb <= frame_bytes_stb_d;
            frame_bytes     <= frame_bytes_d;
            beat_bytes_stb  <= beat_stb_d;
            beat_bytes_amt  <= beat_amt_d;
            proto_err       <= proto_err_d;
        end
    end

`ifdef CR_OSF_OB_MON_LATENCY_EN
    logic [CNT_W-1:0] lat_cnt;
    logic [CNT_W-1:0] lat_inc;
    logic             lat_done;

    assign lat_inc  = (&lat_cnt) ? lat_cnt : lat_cnt + CNT_W'(1);
    // Only commands that really started report a latency; an orphan CQE does not.
    assign lat_done = cqe_exit_d && (cmd_st != CMD_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt         <= '0;
            cmd_latency     <= '0;
            cmd_latency_stb <= 1'b0;
        end else begin
            if (cmd_st == CMD_IDLE && is_rqe) lat_cnt <= '0;
            else if (cmd_active)              lat_cnt <= lat_inc;
            cmd_latency_stb <= lat_done;
            if (lat_done) cmd_latency <= lat_inc;
        end
    end
`else
    assign cmd_latency     = '0;
    assign cmd_latency_stb = 1'b0;
`endif

endmodule
